// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer.
package demux_pkg;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // True when sel addresses an existing channel of an n-channel demux.
  function automatic logic ch_in_range(input logic [31:0] sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/stream_demux_1ton_if.sv
// Producer-side and consumer-side handshake bundle of the 1-to-N demux.
interface stream_demux_1ton_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CH   = 4
);
  localparam int unsigned SEL_W = $clog2(N_CH);

  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_W-1:0]        s_data;
  logic [SEL_W-1:0]         s_sel;
  logic [N_CH-1:0]          m_valid;
  logic [N_CH-1:0]          m_ready;
  logic [N_CH*DATA_W-1:0]   m_data;

  // master: the environment (producer + consumers); slave: the demux itself
  modport master (
    output s_valid, s_data, s_sel, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_sel, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output register; a write always wins over a same-cycle drain.
module stream_demux_slot #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  assign free = ~valid | rd_ready;

  // data only changes on a write, so it holds after drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux: directed or round-robin steering,
// with a saturating counter of beats dropped for an out-of-range select.
module stream_demux_1ton
  import demux_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned CNT_W  = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  stream_demux_1ton_if.slave  bus,
  output logic [SEL_W-1:0]    rr_ptr,
  output logic [CNT_W-1:0]    drop_cnt
);

  logic [SEL_W-1:0]  target;
  logic              in_range;
  logic              tgt_free;
  logic              accept;
  logic [N_CH-1:0]   slot_free;
  logic [N_CH-1:0]   wr_en;
  logic [N_CH-1:0]   slot_valid;
  logic [DATA_W-1:0] slot_data [N_CH];

  assign target   = (mode == MODE_RR) ? rr_ptr : bus.s_sel;
  assign in_range = ch_in_range(32'(target), N_CH);

  // Decoded lookup avoids indexing past N_CH when N_CH is not a power of 2
  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (target == SEL_W'(k)) tgt_free = slot_free[k];
    end
  end

  // Out-of-range beats are always accepted so they can be discarded
  assign bus.s_ready = in_range ? tgt_free : 1'b1;
  assign accept      = bus.s_valid & bus.s_ready;

  always_comb begin
    wr_en = '0;
    for (int k = 0; k < N_CH; k++) begin
      wr_en[k] = accept & in_range & (target == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    stream_demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[k]),
      .wr_data  (bus.s_data),
      .rd_ready (bus.m_ready[k]),
      .valid    (slot_valid[k]),
      .data     (slot_data[k]),
      .free     (slot_free[k])
    );
    assign bus.m_data[k*DATA_W +: DATA_W] = slot_data[k];
  end

  assign bus.m_valid = slot_valid;

  // Pointer moves only on an accepted round-robin beat, never on a mode change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept && in_range && (mode == MODE_RR)) begin
      rr_ptr <= (rr_ptr == SEL_W'(N_CH - 1)) ? '0 : rr_ptr + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (accept && !in_range && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton: a 4-channel instance for the main
// tests and a 3-channel instance for out-of-range drops.
module tb_stream_demux_1ton;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode4, mode3;
  logic [1:0] rr4, rr3;
  logic [7:0] drop4, drop3;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ptr  = 0;

  logic [7:0] q [4][$];

  always #5 clk = ~clk;

  stream_demux_1ton_if #(.DATA_W(8), .N_CH(4)) bus4 ();
  stream_demux_1ton_if #(.DATA_W(8), .N_CH(3)) bus3 ();

  stream_demux_1ton #(.DATA_W(8), .N_CH(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .bus(bus4), .rr_ptr(rr4), .drop_cnt(drop4)
  );

  stream_demux_1ton #(.DATA_W(8), .N_CH(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .bus(bus3), .rr_ptr(rr3), .drop_cnt(drop3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every output handshake pops that channel's expected payload
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (bus4.m_valid[k] && bus4.m_ready[k]) begin
          if (q[k].size() == 0) begin
            n_checks++;
            $display("FAIL mon_ch%0d: got unexpected beat 0x%0h, expected none", k,
                     bus4.m_data[k*8 +: 8]);
          end else begin
            logic [7:0] e;
            e = q[k].pop_front();
            check($sformatf("mon_ch%0d", k), 32'(bus4.m_data[k*8 +: 8]), 32'(e));
          end
        end
      end
    end
  end

  // Issue one beat on dut4 (call at posedge+1); bounded wait for acceptance
  task automatic send(input logic [1:0] sel, input logic [7:0] d);
    int waited = 0;
    int ch;
    bus4.s_valid = 1'b1;
    bus4.s_sel   = sel;
    bus4.s_data  = d;
    @(negedge clk);
    while (!bus4.s_ready && waited < 50) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    if (bus4.s_ready) begin
      ch = mode4 ? exp_ptr : int'(sel);
      if (mode4) begin
        check("rr_ptr_at_accept", 32'(rr4), 32'(exp_ptr));
        exp_ptr = (exp_ptr + 1) % 4;
      end
      q[ch].push_back(d);
    end else begin
      n_checks++;
      $display("FAIL send_timeout: got s_ready=0 for 50 cycles, expected acceptance of 0x%0h", d);
    end
    @(posedge clk);
    #1;
    bus4.s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier end");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    // ---- reset with random inputs
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      mode4 = 1'($urandom); mode3 = 1'($urandom);
      bus4.s_valid = 1'($urandom); bus4.s_sel = 2'($urandom);
      bus4.s_data = 8'($urandom); bus4.m_ready = 4'($urandom);
      bus3.s_valid = 1'($urandom); bus3.s_sel = 2'($urandom);
      bus3.s_data = 8'($urandom); bus3.m_ready = 3'($urandom);
    end
    @(negedge clk);
    check("rst_m_valid", 32'(bus4.m_valid), 32'h0);
    check("rst_m_data", bus4.m_data, 32'h0);
    check("rst_rr_ptr", 32'(rr4), 32'h0);
    check("rst_drop_cnt", 32'(drop4), 32'h0);
    @(posedge clk); #1;
    mode4 = 1'b0; mode3 = 1'b0;
    bus4.s_valid = 1'b0; bus4.s_sel = '0; bus4.s_data = '0; bus4.m_ready = 4'hF;
    bus3.s_valid = 1'b0; bus3.s_sel = '0; bus3.s_data = '0; bus3.m_ready = 3'h0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed, back-to-back to channels 0..3
    for (int i = 0; i < 4; i++) begin
      bus4.s_valid = 1'b1;
      bus4.s_sel   = 2'(i);
      bus4.s_data  = 8'(8'hA0 + i);
      @(negedge clk);
      check("dir_s_ready", 32'(bus4.s_ready), 32'h1);
      check("dir_m_valid_pulse", 32'(bus4.m_valid), (i == 0) ? 32'h0 : 32'(1 << (i - 1)));
      q[i].push_back(8'(8'hA0 + i));
      @(posedge clk); #1;
    end
    bus4.s_valid = 1'b0;
    @(negedge clk);
    check("dir_m_valid_last", 32'(bus4.m_valid), 32'h8);
    @(posedge clk); #1;
    @(negedge clk);
    check("dir_m_valid_idle", 32'(bus4.m_valid), 32'h0);
    check("dir_m_data_hold", bus4.m_data, 32'hA3A2A1A0);
    @(posedge clk); #1;

    // ---- backpressure on channel 2
    bus4.m_ready = 4'b1011;
    send(2'd2, 8'h11);
    bus4.s_valid = 1'b1; bus4.s_sel = 2'd2; bus4.s_data = 8'h22;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bp_s_ready_low", 32'(bus4.s_ready), 32'h0);
      check("bp_ch2_held", 32'(bus4.m_data[23:16]), 32'h11);
      check("bp_ch2_valid", 32'(bus4.m_valid[2]), 32'h1);
      @(posedge clk); #1;
    end
    bus4.m_ready = 4'hF;
    @(negedge clk);
    check("bp_s_ready_refill", 32'(bus4.s_ready), 32'h1);
    q[2].push_back(8'h22);
    @(posedge clk); #1;
    bus4.s_valid = 1'b0;
    @(negedge clk);
    check("bp_ch2_valid_stays", 32'(bus4.m_valid[2]), 32'h1);
    check("bp_ch2_new", 32'(bus4.m_data[23:16]), 32'h22);
    @(posedge clk); #1;

    // ---- round robin, 6 beats then a stall on channel 3
    mode4 = 1'b1;
    for (int i = 0; i < 6; i++) send(2'd0, 8'(i));
    check("rr_ptr_after6", 32'(rr4), 32'h2);
    @(negedge clk);
    check("rr_m_data", bus4.m_data, 32'h03020504);
    @(posedge clk); #1;
    bus4.m_ready = 4'b0111;
    send(2'd0, 8'h62); send(2'd0, 8'h63); send(2'd0, 8'h60);
    send(2'd0, 8'h61); send(2'd0, 8'h72);
    check("rr_ptr_at_stall", 32'(rr4), 32'h3);
    fork
      send(2'd0, 8'h73);
      begin
        repeat (3) begin
          @(negedge clk);
          check("rr_stall_s_ready", 32'(bus4.s_ready), 32'h0);
          check("rr_stall_ptr", 32'(rr4), 32'h3);
        end
        @(posedge clk); #1;
        bus4.m_ready = 4'hF;
      end
    join
    check("rr_ptr_wrap", 32'(rr4), 32'h0);
    check("rr_ch3_loaded", 32'(bus4.m_data[31:24]), 32'h73);

    // ---- mode switching keeps the pointer
    send(2'd0, 8'hB0);
    check("ms_ptr_rr1", 32'(rr4), 32'h1);
    mode4 = 1'b0;
    send(2'd0, 8'hB1);
    check("ms_ptr_directed", 32'(rr4), 32'h1);
    mode4 = 1'b1;
    send(2'd3, 8'hB2);
    check("ms_ch1_data", 32'(bus4.m_data[15:8]), 32'hB2);
    check("ms_ptr_after", 32'(rr4), 32'h2);
    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'h0);

    // ---- 3-channel instance: out-of-range select drops
    bus3.s_valid = 1'b1; bus3.s_sel = 2'd1; bus3.s_data = 8'h5A;
    @(negedge clk);
    check("n3_load_ready", 32'(bus3.s_ready), 32'h1);
    @(posedge clk); #1;
    bus3.s_sel = 2'd3; bus3.s_data = 8'hEE;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus3.s_ready) bad++;
      if (i == 100) check("n3_drop_cnt_100", 32'(drop3), 32'd100);
      @(posedge clk); #1;
    end
    bus3.s_valid = 1'b0;
    @(negedge clk);
    check("n3_ready_low_cycles", 32'(bad), 32'h0);
    check("n3_drop_sat", 32'(drop3), 32'hFF);
    check("n3_m_valid", 32'(bus3.m_valid), 32'h2);
    check("n3_m_data", 32'(bus3.m_data), 32'h005A00);
    check("n3_rr_ptr", 32'(rr3), 32'h0);
    @(posedge clk); #1;

    // ---- asynchronous reset mid-stream
    mode4 = 1'b0;
    bus4.m_ready = 4'h0;
    send(2'd0, 8'hC0);
    send(2'd1, 8'hC1);
    bus4.s_valid = 1'b1; bus4.s_sel = 2'd2; bus4.s_data = 8'hC2;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", 32'(bus4.m_valid), 32'h0);
    check("arst_m_data", bus4.m_data, 32'h0);
    check("arst_rr_ptr", 32'(rr4), 32'h0);
    check("arst_drop3", 32'(drop3), 32'h0);
    check("arst_m_valid3", 32'(bus3.m_valid), 32'h0);
    for (int k = 0; k < 4; k++) q[k].delete();
    bus4.s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
